// File: rtl/mod_reduction_arbiter.sv
// ---------------------------------------------------------------------------
// mod_reduction_arbiter
//
// Shares one ModReduction unit among NREQ requesters. A round-robin search
// starting at ptr picks a requester in IDLE, its 2*width-bit operand is
// latched onto red_a and red_enable is raised for the whole job. When the
// reducer signals done (or the watchdog expires) the result is returned to
// the winner together with a one-cycle, one-hot ack.
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous, active-high reset
//   req         per-requester request, held with operand until ack
//   req_a       packed operands, requester i at [(i+1)*2*width-1 : i*2*width]
//   ack         one-hot, one-cycle completion pulse
//   result      reduced value, valid while ack is nonzero
//   err         high with ack when the job was aborted by the watchdog
//   busy        high while a job is running or being acknowledged
//   red_enable  reducer enable, high only in BUSY
//   red_a       reducer operand, registered and stable for the whole job
//   red_done    reducer completion (ignored outside BUSY)
//   red_r       reducer result
// ---------------------------------------------------------------------------
module mod_reduction_arbiter #(
  parameter int NREQ    = 4,
  parameter int width   = 128,
  parameter int TIMEOUT = 1024
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*2*width-1:0]   req_a,
  output logic [NREQ-1:0]           ack,
  output logic [width-1:0]          result,
  output logic                      err,
  output logic                      busy,
  output logic                      red_enable,
  output logic [2*width-1:0]        red_a,
  input  logic                      red_done,
  input  logic [width-1:0]          red_r
);

  localparam int AW  = 2 * width;
  localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WDW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Registered state
  logic [1:0]       state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    gnt_q, gnt_d;
  logic [WDW-1:0]   wd_q, wd_d;
  logic [AW-1:0]    red_a_q, red_a_d;
  logic             red_enable_q, red_enable_d;
  logic [NREQ-1:0]  ack_q, ack_d;
  logic [width-1:0] result_q, result_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;

  // Combinational helpers
  logic             pick_found_s;
  logic [IW-1:0]    pick_idx_s;
  logic [IW:0]      cand_s;
  logic [AW-1:0]    pick_op_s;
  logic [IW-1:0]    ptr_inc_s;

  // Round-robin search: walk the offsets from high to low so the last hit
  // written is the one closest to ptr (the highest-priority candidate).
  always_comb begin
    pick_found_s = 1'b0;
    pick_idx_s   = '0;
    cand_s       = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand_s = {1'b0, ptr_q} + (IW + 1)'(i);
      if (cand_s >= (IW + 1)'(NREQ)) begin
        cand_s = cand_s - (IW + 1)'(NREQ);
      end else begin
        cand_s = cand_s;
      end
      if (req[cand_s[IW-1:0]]) begin
        pick_found_s = 1'b1;
        pick_idx_s   = cand_s[IW-1:0];
      end else begin
        pick_found_s = pick_found_s;
      end
    end
  end

  // Operand multiplexer for the candidate winner.
  always_comb begin
    pick_op_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_idx_s == IW'(i)) begin
        pick_op_s = req_a[i*AW +: AW];
      end else begin
        pick_op_s = pick_op_s;
      end
    end
  end

  // Next pointer is one past the served requester, wrapping at NREQ.
  always_comb begin
    if (gnt_q == IW'(NREQ - 1)) begin
      ptr_inc_s = '0;
    end else begin
      ptr_inc_s = gnt_q + IW'(1);
    end
  end

  // Sequencer next-state logic: IDLE grants, BUSY waits for done or the
  // watchdog, RESP pulses ack and advances the round-robin pointer.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    gnt_d        = gnt_q;
    wd_d         = wd_q;
    red_a_d      = red_a_q;
    red_enable_d = red_enable_q;
    ack_d        = '0;
    result_d     = result_q;
    err_d        = err_q;
    busy_d       = busy_q;

    case (state_q)
      ST_IDLE: begin
        if (pick_found_s) begin
          state_d      = ST_BUSY;
          gnt_d        = pick_idx_s;
          red_a_d      = pick_op_s;
          wd_d         = '0;
          red_enable_d = 1'b1;
          busy_d       = 1'b1;
        end else begin
          state_d      = ST_IDLE;
          red_enable_d = 1'b0;
          busy_d       = 1'b0;
        end
      end

      ST_BUSY: begin
        wd_d = wd_q + WDW'(1);
        // done wins over the watchdog when both happen in the same cycle
        if (red_done) begin
          state_d      = ST_RESP;
          result_d     = red_r;
          err_d        = 1'b0;
          red_enable_d = 1'b0;
          ack_d[gnt_q] = 1'b1;
        end else if (wd_q == WDW'(TIMEOUT - 1)) begin
          state_d      = ST_RESP;
          result_d     = '0;
          err_d        = 1'b1;
          red_enable_d = 1'b0;
          ack_d[gnt_q] = 1'b1;
        end else begin
          state_d      = ST_BUSY;
          red_enable_d = 1'b1;
        end
      end

      ST_RESP: begin
        // No grant here: red_enable stays low for RESP plus IDLE so the
        // reducer always sees a fresh rising edge for the next job.
        state_d      = ST_IDLE;
        ptr_d        = ptr_inc_s;
        red_enable_d = 1'b0;
        busy_d       = 1'b0;
        result_d     = '0;
        err_d        = 1'b0;
      end

      default: begin
        state_d      = ST_IDLE;
        red_enable_d = 1'b0;
        busy_d       = 1'b0;
        result_d     = '0;
        err_d        = 1'b0;
        wd_d         = '0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      gnt_q        <= '0;
      wd_q         <= '0;
      red_a_q      <= '0;
      red_enable_q <= 1'b0;
      ack_q        <= '0;
      result_q     <= '0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      gnt_q        <= gnt_d;
      wd_q         <= wd_d;
      red_a_q      <= red_a_d;
      red_enable_q <= red_enable_d;
      ack_q        <= ack_d;
      result_q     <= result_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
    end
  end

  assign ack        = ack_q;
  assign result     = result_q;
  assign err        = err_q;
  assign busy       = busy_q;
  assign red_enable = red_enable_q;
  assign red_a      = red_a_q;

endmodule

// File: tb/tb_mod_reduction_arbiter.sv
// ---------------------------------------------------------------------------
// Bench for mod_reduction_arbiter: a reducer stub (mod 37, programmable
// latency, optional hang), a job-level round-robin reference model, directed
// scenarios and a randomized phase.
// ---------------------------------------------------------------------------
module tb_mod_reduction_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 128;
  localparam int AW   = 2 * W;
  localparam int TMO  = 8;
  localparam int P    = 37;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NREQ-1:0]      req;
  logic [NREQ*AW-1:0]   req_a;
  logic [NREQ-1:0]      ack;
  logic [W-1:0]         result;
  logic                 err;
  logic                 busy;
  logic                 red_enable;
  logic [AW-1:0]        red_a;
  logic                 red_done = 1'b0;
  logic [W-1:0]         red_r = '0;

  always #5 clk = ~clk;

  mod_reduction_arbiter #(.NREQ(NREQ), .width(W), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .req(req), .req_a(req_a), .ack(ack),
    .result(result), .err(err), .busy(busy), .red_enable(red_enable),
    .red_a(red_a), .red_done(red_done), .red_r(red_r)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Reducer stub: done pulses stub_lat cycles after enable is first seen.
  int stub_lat   = 2;
  bit stub_hang  = 1'b0;
  bit stub_stray = 1'b0;
  int stub_cnt   = 0;

  always @(posedge clk) begin
    if (reset) begin
      red_done <= 1'b0;
      red_r    <= '0;
      stub_cnt <= 0;
    end else begin
      red_done <= 1'b0;
      red_r    <= {$urandom, $urandom, $urandom, $urandom};
      if (red_enable) begin
        stub_cnt <= stub_cnt + 1;
        if (!stub_hang && stub_cnt == stub_lat) begin
          red_done <= 1'b1;
          red_r    <= W'(red_a % P);
        end
      end else begin
        stub_cnt <= 0;
        if (stub_stray) red_done <= 1'b1;
      end
    end
  end

  // Job-level reference model
  typedef struct { int idx; logic [W-1:0] res; logic e; } ack_t;
  ack_t acks_q[$];

  int          cyc = 0;
  bit          m_job = 1'b0;
  int          m_g, m_win, m_lat, m_lim;
  int          m_ptr = 0;
  int          m_armed = 0;
  bit          m_hang;
  logic [AW-1:0] m_op;

  function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
    for (int i = 0; i < NREQ; i++) begin
      if (r[(p + i) % NREQ]) return (p + i) % NREQ;
    end
    return 0;
  endfunction

  // At each falling edge: the inputs visible belong to the previous cycle
  // (they change just after the falling edge), the outputs to this cycle.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        m_job   = 1'b0;
        m_ptr   = 0;
        m_armed = cyc;
      end else if (!m_job && (cyc - 1) >= m_armed && req != '0) begin
        m_job  = 1'b1;
        m_g    = cyc - 1;
        m_win  = rr_pick(req, m_ptr);
        m_op   = req_a[m_win*AW +: AW];
        m_lat  = stub_lat;
        m_hang = stub_hang;
        m_lim  = m_hang ? (TMO + 1) : (m_lat + 3);
      end
      if (ack != '0) begin
        if (!m_job) begin
          check("spurious_ack", ack, '0);
        end else begin
          ack_t a;
          check("ack_time", cyc - m_g, m_lim);
          check("ack_who", ack, NREQ'(1) << m_win);
          check("ack_err", err, m_hang);
          check("ack_result", result, m_hang ? '0 : (m_op % P));
          check("busy_at_ack", busy, 1'b1);
          a.idx = m_win; a.res = result; a.e = err;
          acks_q.push_back(a);
          m_ptr   = (m_win + 1) % NREQ;
          m_job   = 1'b0;
          m_armed = cyc + 1;
        end
      end else begin
        check("busy", busy, m_job);
        check("red_enable", red_enable, m_job);
        if (m_job) begin
          check("red_a", red_a, m_op);
          if (cyc - m_g > m_lim) begin
            check("ack_late", cyc - m_g, m_lim);
            m_job   = 1'b0;
            m_armed = cyc + 1;
          end
        end
      end
    end
  end

  // Stimulus helpers
  task automatic tick();
    @(negedge clk);
    #1;
    req = req & ~ack;
  endtask

  task automatic raise(input int i, input logic [AW-1:0] op);
    req[i] = 1'b1;
    req_a[i*AW +: AW] = op;
  endtask

  task automatic wait_acks(input int n, input int budget);
    int k = 0;
    while (acks_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    check("ack_count", acks_q.size(), n);
  endtask

  task automatic expect_ack(input string tag, input int idx, input int res, input bit e);
    ack_t a;
    a.idx = -1; a.res = '0; a.e = 1'b0;
    if (acks_q.size() > 0) a = acks_q.pop_front();
    check({tag, "_idx"}, a.idx, idx);
    check({tag, "_res"}, a.res, res);
    check({tag, "_err"}, a.e, e);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ack"}, ack, '0);
    check({tag, "_result"}, result, '0);
    check({tag, "_err"}, err, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_en"}, red_enable, 1'b0);
    check({tag, "_red_a"}, red_a, '0);
  endtask

  initial begin
    logic [AW-1:0] op;
    int k;
    reset = 1'b1; req = '0; req_a = '0;
    repeat (3) tick();
    check_reset_outputs("rst");
    reset = 1'b0;

    // single request and small operands
    raise(0, 382);
    wait_acks(1, 50);
    expect_ack("single", 0, 12, 1'b0);
    tick();
    check("busy_fall", busy, 1'b0);
    check("ack_once", ack, '0);
    raise(0, 20);  wait_acks(1, 50); expect_ack("below_p", 0, 20, 1'b0);
    raise(0, 0);   wait_acks(1, 50); expect_ack("zero", 0, 0, 1'b0);

    // done pulses while idle must be ignored
    repeat (2) tick();
    stub_stray = 1'b1; tick(); stub_stray = 1'b0;
    repeat (3) tick();
    check("stray_done", acks_q.size(), 0);

    // full contention from ptr=0, twice
    reset = 1'b1; tick(); reset = 1'b0;
    for (int rep = 0; rep < 2; rep++) begin
      raise(0, 40); raise(1, 75); raise(2, 111); raise(3, 1000);
      wait_acks(4, 100);
      expect_ack("cont0", 0, 3, 1'b0);
      expect_ack("cont1", 1, 1, 1'b0);
      expect_ack("cont2", 2, 0, 1'b0);
      expect_ack("cont3", 3, 1, 1'b0);
    end

    // round-robin pointer behaviour
    raise(2, 5);   wait_acks(1, 50); expect_ack("rr_a", 2, 5, 1'b0);
    raise(0, 50); raise(2, 77);
    wait_acks(2, 80);
    expect_ack("rr_b", 0, 13, 1'b0);
    expect_ack("rr_c", 2, 3, 1'b0);
    raise(2, 100); wait_acks(1, 50); expect_ack("rr_d", 2, 26, 1'b0);

    // watchdog abort, then normal service, then done on the last BUSY cycle
    stub_hang = 1'b1;
    raise(1, 999); wait_acks(1, 50); expect_ack("timeout", 1, 0, 1'b1);
    stub_hang = 1'b0;
    raise(3, 38);  wait_acks(1, 50); expect_ack("after_to", 3, 1, 1'b0);
    stub_lat = 6;
    raise(1, 79);  wait_acks(1, 50); expect_ack("done_prio", 1, 5, 1'b0);
    stub_lat = 2;

    // reset two cycles after grant abandons the job
    raise(0, 382);
    k = 0;
    while (!busy && k < 20) begin tick(); k++; end
    check("busy_rise", busy, 1'b1);
    tick();
    reset = 1'b1;
    tick();
    check_reset_outputs("rst_mid");
    reset = 1'b0;
    check("rst_no_ack", acks_q.size(), 0);
    wait_acks(1, 50);
    expect_ack("after_rst", 0, 12, 1'b0);

    // randomized traffic, checked by the model
    for (int it = 0; it < 600; it++) begin
      tick();
      if (!busy && ($urandom % 4) == 0) begin
        stub_lat  = $urandom_range(0, 6);
        stub_hang = (($urandom % 8) == 0);
      end
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i] && ($urandom % 3) == 0) begin
          if (($urandom % 3) == 0) begin
            op = AW'($urandom_range(0, 100));
          end else begin
            for (int w = 0; w < AW / 32; w++) op[w*32 +: 32] = $urandom;
          end
          raise(i, op);
        end else if (req[i] && ($urandom % 20) == 0) begin
          req[i] = 1'b0;
        end
      end
    end
    req = '0;
    repeat (30) tick();
    check("drained", m_job, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
